cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Common-data-bus arbiter for the out-of-order backend. Functional units (ALU, multiplier, load unit, …) hand over completed results as {tag, data}.
- The arbiter buffers one result per requester and grants the single broadcast bus round-robin. It drives the registered broadcast (cdb_valid/cdb_tag/cdb_data) that every reservation station snoops to wake waiting operands.
- Sequences the result path into the reservation stations; it does not issue or dispatch.

Parameters:
- NREQ, 4, number of result requesters; legal range 2..8.
- TAG_W, 5, width of the physical/ROB destination tag.
- DATA_W, 32, result width.
- PTR_W, $clog2(NREQ), round-robin pointer width (derived; not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all buffered and outgoing results.
- req_valid  input  NREQ  requester i offers a result.
- req_tag  input  NREQ*TAG_W  tag of requester i, slice [i*TAG_W +: TAG_W].
- req_data  input  NREQ*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  requester i may hand over this cycle.
- cdb_valid  output  1  broadcast valid; high for exactly one cycle per result.
- cdb_tag  output  TAG_W  broadcast tag.
- cdb_data  output  DATA_W  broadcast value.
- cdb_src  output  PTR_W  index of the requester that produced the broadcast.

Behaviour:
- State per requester: held[i], htag[i], hdata[i]. Also a round-robin pointer ptr and the registered cdb_* outputs.
- Reset (rst=0, asynchronous): held=0, ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0. Reset mid-operation discards all held results with no broadcast.
- Grant (combinational):
  - Scan i = ptr, ptr+1, … mod NREQ.
  - grant is one-hot on the first i with held[i]=1; grant is 0 if none are held.
- Ready: req_ready[i] = ~held[i] | grant[i]. This is combinational from state only, never from req_valid.
- Handshake: a result is accepted on an edge where req_valid[i] & req_ready[i] (and flush=0).
- On accept:
  - held[i]<=1, htag[i]<=req_tag, hdata[i]<=req_data.
  - A simultaneous grant to i plus a new accept leaves held[i]=1 holding the new data. This gives throughput of 1 result/cycle per requester.
- Tag 0 is reserved as "no tag" and must never be broadcast. A request with tag 0 is accepted (ready honoured) but not stored; held[i] is left cleared unless re-set.
- Broadcast, on an edge with any grant and flush=0:
  - cdb_valid<=1, cdb_tag<=htag[w], cdb_data<=hdata[w], cdb_src<=w.
  - held[w]<=0 unless re-filled the same edge.
  - ptr<=(w+1) mod NREQ.
- With no grant: cdb_valid<=0; cdb_tag, cdb_data and cdb_src hold their values; ptr unchanged.
- Latency: accept at edge E; result on cdb after edge E+1 at the earliest. A stored result is broadcast within NREQ grants (starvation bound).
- Flush=1 at an edge:
  - held<=0 and cdb_valid<=0; ptr unchanged.
  - Requests presented that cycle are dropped, even with ready=1.
  - Flush has priority over accept and broadcast.
- Per-requester order is preserved: FIFO of depth 1, so a newer result never overtakes an older one.
- No combinational path from req_* to cdb_*.

Test Plan:
- Reset: hold rst=0 with req_valid=4'hF → cdb_valid=0, req_ready=4'hF, ptr=0. Release, idle → cdb_valid stays 0.
- Single request: req0 tag=5'd3 data=32'hDEAD_BEEF for one cycle → one cycle later cdb_valid=1, tag=3, data=DEADBEEF, src=0. Next cycle cdb_valid=0.
- Contention: all four requesters valid in the same cycle with tags 1,2,3,4 → broadcasts on four consecutive cycles in src order 0,1,2,3, req_ready deasserted while held. Then requesters 0 and 3 fire together → ptr=0, so src 0 then 3.
- Streaming: requester 2 valid every cycle for 6 cycles with tags 10..15 → req_ready[2] stays 1 after the first, cdb_valid=1 for 6 consecutive cycles, tags in order 10..15.
- Tag 0 and flush: req1 tag=0 → no broadcast. Fill 0,1,2, then flush on the cycle after the first broadcast → only one broadcast total, held cleared, next request broadcasts normally.
- Reset mid-operation: three held results, assert rst asynchronously mid-cycle → cdb_valid drops immediately, no broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result handover and common-data-bus broadcast signals between requesters and the arbiter.
// master = requester/snooper side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [PTR_W-1:0]       cdb_src;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter, one buffered result per requester; broadcast >= 1 cycle after accept.
// Backpressure: req_ready[i] is low only while slot i is full and not being granted this cycle.
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  cdb_arbiter_if.slave      bus
);
  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]   held;
  logic [TAG_W-1:0]  htag  [NREQ];
  logic [DATA_W-1:0] hdata [NREQ];
  logic [PTR_W-1:0]  ptr;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [PTR_W-1:0]  cdb_src_q;

  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  scan_idx;
  logic              any_grant;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [NREQ-1:0]   accept;

  // Rotating priority scan starting at ptr; first held slot wins.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    scan_idx  = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % NREQ);
      if (!any_grant && held[scan_idx]) begin
        any_grant       = 1'b1;
        grant[scan_idx] = 1'b1;
        gidx            = scan_idx;
      end
    end
  end

  assign ptr_nxt       = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign bus.req_ready = ~held | grant;
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held        <= '0;
      ptr         <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        htag[i]  <= '0;
        hdata[i] <= '0;
      end
    end else if (flush) begin
      held        <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i])
          held[i] <= 1'b0;
        // Tag 0 means "no tag": the handshake completes but nothing is stored.
        if (accept[i] && (bus.req_tag[i*TAG_W +: TAG_W] != '0)) begin
          held[i]  <= 1'b1;
          htag[i]  <= bus.req_tag[i*TAG_W +: TAG_W];
          hdata[i] <= bus.req_data[i*DATA_W +: DATA_W];
        end
      end
      if (any_grant) begin
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= htag[gidx];
        cdb_data_q  <= hdata[gidx];
        cdb_src_q   <= gidx;
        ptr         <= ptr_nxt;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed stimulus for cdb_arbiter; expected broadcasts are queued at issue time
// and a negedge monitor pops and compares every cdb_valid cycle.
module tb_cdb_arbiter;
  localparam int NREQ   = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  int errors = 0;
  int checks = 0;
  int bcast_cnt = 0;
  int base;
  exp_t exp_q[$];

  cdb_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_tag[i*TAG_W +: TAG_W] = t;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_bc(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d, input logic [1:0] s);
    exp_t e;
    e.tag = t;
    e.data = d;
    e.src = s;
    exp_q.push_back(e);
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.cdb_valid === 1'b1) begin
      bcast_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bcast: got tag=%0h src=%0d, expected no broadcast (t=%0t)",
                 bus.cdb_tag, bus.cdb_src, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cdb_tag",  64'(bus.cdb_tag),  64'(e.tag));
        chk("cdb_data", 64'(bus.cdb_data), 64'(e.data));
        chk("cdb_src",  64'(bus.cdb_src),  64'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    // Reset held with all requesters offering.
    bus.req_valid = 4'hF;
    bus.req_tag = {5'd4, 5'd3, 5'd2, 5'd1};
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'hF);
    chk("rst_ptr",       64'(dut.ptr),       64'd0);
    clear_reqs();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("idle_bcast_cnt", 64'(bcast_cnt), 64'd0);

    // Contention: all four at once, ptr=0 -> src 0,1,2,3.
    base = bcast_cnt;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, TAG_W'(i + 1), 32'h1000_0000 + DATA_W'(i));
      expect_bc(TAG_W'(i + 1), 32'h1000_0000 + DATA_W'(i), 2'(i));
    end
    tick();
    clear_reqs();
    @(negedge clk);
    chk("cont_ready_e0", 64'(bus.req_ready), 64'h1);
    tick();
    @(negedge clk);
    chk("cont_ready_e1", 64'(bus.req_ready), 64'h3);
    repeat (6) tick();
    chk("cont_bcast_cnt", 64'(bcast_cnt - base), 64'd4);

    // Requesters 0 and 3 together, ptr back at 0 -> src 0 then 3.
    base = bcast_cnt;
    set_req(0, 5'd5, 32'hAAAA_0000);
    set_req(3, 5'd6, 32'hBBBB_0003);
    expect_bc(5'd5, 32'hAAAA_0000, 2'd0);
    expect_bc(5'd6, 32'hBBBB_0003, 2'd3);
    tick();
    clear_reqs();
    repeat (4) tick();
    chk("pair_bcast_cnt", 64'(bcast_cnt - base), 64'd2);

    // Single request: visible one edge after acceptance, for exactly one cycle.
    base = bcast_cnt;
    set_req(0, 5'd3, 32'hDEAD_BEEF);
    expect_bc(5'd3, 32'hDEAD_BEEF, 2'd0);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("single_lat_e0", 64'(bus.cdb_valid), 64'd0);
    @(negedge clk);
    chk("single_lat_e1", 64'(bus.cdb_valid), 64'd1);
    @(negedge clk);
    chk("single_pulse",  64'(bus.cdb_valid), 64'd0);
    tick();
    chk("single_bcast_cnt", 64'(bcast_cnt - base), 64'd1);

    // Streaming on requester 2: one result per cycle, back-to-back broadcasts.
    base = bcast_cnt;
    for (int k = 0; k < 6; k++) begin
      set_req(2, TAG_W'(10 + k), 32'h5000_0000 + DATA_W'(k));
      expect_bc(TAG_W'(10 + k), 32'h5000_0000 + DATA_W'(k), 2'd2);
      @(negedge clk);
      chk("stream_ready", 64'(bus.req_ready[2]), 64'd1);
      if (k >= 2) chk("stream_valid", 64'(bus.cdb_valid), 64'd1);
      tick();
    end
    clear_reqs();
    @(negedge clk);
    chk("stream_valid_t1", 64'(bus.cdb_valid), 64'd1);
    @(negedge clk);
    chk("stream_valid_t2", 64'(bus.cdb_valid), 64'd1);
    @(negedge clk);
    chk("stream_end", 64'(bus.cdb_valid), 64'd0);
    tick();
    chk("stream_bcast_cnt", 64'(bcast_cnt - base), 64'd6);

    // Tag 0 is handshaken but never broadcast.
    base = bcast_cnt;
    set_req(1, 5'd0, 32'h1234_5678);
    @(negedge clk);
    chk("tag0_ready", 64'(bus.req_ready[1]), 64'd1);
    tick();
    clear_reqs();
    repeat (3) tick();
    chk("tag0_bcast_cnt", 64'(bcast_cnt - base), 64'd0);
    chk("tag0_ready_after", 64'(bus.req_ready), 64'hF);

    // Flush after first broadcast: ptr=3 so src 0 goes first, rest squashed.
    base = bcast_cnt;
    set_req(0, 5'd20, 32'h2000_0000);
    set_req(1, 5'd21, 32'h2000_0001);
    set_req(2, 5'd22, 32'h2000_0002);
    expect_bc(5'd20, 32'h2000_0000, 2'd0);
    tick();
    clear_reqs();
    tick();
    flush = 1'b1;
    set_req(3, 5'd9, 32'h9999_9999);
    tick();
    flush = 1'b0;
    clear_reqs();
    @(negedge clk);
    chk("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("flush_ready",     64'(bus.req_ready), 64'hF);
    repeat (3) tick();
    chk("flush_bcast_cnt", 64'(bcast_cnt - base), 64'd1);
    base = bcast_cnt;
    set_req(2, 5'd7, 32'h0707_0707);
    expect_bc(5'd7, 32'h0707_0707, 2'd2);
    tick();
    clear_reqs();
    repeat (3) tick();
    chk("post_flush_bcast_cnt", 64'(bcast_cnt - base), 64'd1);

    // Asynchronous reset while a broadcast is on the bus and two results wait.
    base = bcast_cnt;
    set_req(0, 5'd24, 32'h2400_0000);
    set_req(1, 5'd25, 32'h2500_0000);
    set_req(2, 5'd26, 32'h2600_0000);
    expect_bc(5'd24, 32'h2400_0000, 2'd0);
    tick();
    clear_reqs();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("mid_rst_ready",     64'(bus.req_ready), 64'hF);
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("mid_rst_bcast_cnt", 64'(bcast_cnt - base), 64'd1);
    chk("mid_rst_ptr",       64'(dut.ptr),           64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
